// File: rtl/core_pkg.sv
// Shared core-wide constants and types used by the front-end pipeline blocks.
package core_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fb_storage.sv
// Entry storage for the fetch buffer: one synchronous write port, one asynchronous read port.
module fb_storage #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Contents are never reset; validity is tracked by the pointers and count.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Decoupling FIFO between IF and ID: holds {pc, instr} pairs, presents NOP when empty.
module fetch_buffer #(
    parameter int               XLEN      = core_pkg::XLEN,
    parameter int               DEPTH     = 4,
    parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(core_pkg::NOP_INSTR)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;
    logic [2*XLEN-1:0] w_rd_entry;

    // Handshake: a transfer happens on a side only when its valid and ready are both
    // high at the clock edge. Ready/valid here depend only on registered count, so
    // neither side ever sees a combinational path through the other.
    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid  && in_ready  && !flush;
    assign w_pop     = out_valid && out_ready && !flush;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fb_storage #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .i_we    (w_push && !reset),
        .i_waddr (r_tail),
        .i_wdata ({in_pc, in_instr}),
        .i_raddr (r_head),
        .o_rdata (w_rd_entry)
    );

    assign out_pc    = out_valid ? w_rd_entry[2*XLEN-1:XLEN] : '0;
    assign out_instr = out_valid ? w_rd_entry[XLEN-1:0]      : NOP_INSTR;

endmodule
